// File: rtl/light_pkg.sv
// -----------------------------------------------------------------------------
// light_pkg
// Shared types and default widths for the light tag checker slice.
//   state_t   : checker FSM states (IDLE, CHECK, SEND)
//   DEF_*     : default plaintext / beat / tag widths
//   num_beats : beats per plaintext chunk
//   idx_width : width of a beat index counter (at least 1 bit)
// -----------------------------------------------------------------------------
package light_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2
  } state_t;

  localparam int DEF_PT_WIDTH   = 640;
  localparam int DEF_BEAT_WIDTH = 128;
  localparam int DEF_TAG_WIDTH  = 128;

  function automatic int num_beats(input int pt_w, input int beat_w);
    return pt_w / beat_w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/light_beat_serializer.sv
// -----------------------------------------------------------------------------
// light_beat_serializer
// Parallel-in / serial-out stage: takes a PT_WIDTH chunk and releases it as
// BEAT_WIDTH beats, least-significant beat first, with val/rdy/last.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   load, load_data  : load a new chunk (only while idle)
//   out_data/out_last/out_val/out_rdy : beat stream
//   done             : pulses when the final beat is accepted
// -----------------------------------------------------------------------------
module light_beat_serializer
  import light_pkg::*;
#(
  parameter int PT_WIDTH   = DEF_PT_WIDTH,
  parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [PT_WIDTH-1:0]   load_data,
  output logic [BEAT_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic                  done
);

  localparam int NB = num_beats(PT_WIDTH, BEAT_WIDTH);
  localparam int IW = idx_width(NB);

  logic [PT_WIDTH-1:0] sh_p1;
  logic [IW-1:0]       beat_idx;
  logic                active;
  logic                last_beat;

  assign last_beat = (beat_idx == IW'(NB - 1));

  // Stage p1 -> beat output: the current beat always sits in the low slice,
  // so each accepted beat shifts the next one down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      beat_idx <= '0;
      sh_p1    <= '0;
    end else if (load) begin
      active   <= 1'b1;
      beat_idx <= '0;
      sh_p1    <= load_data;
    end else if (active && out_rdy) begin
      sh_p1 <= sh_p1 >> BEAT_WIDTH;
      if (last_beat) begin
        active   <= 1'b0;
        beat_idx <= '0;
      end else begin
        beat_idx <= beat_idx + 1'b1;
      end
    end
  end

  assign out_val  = active;
  assign out_data = active ? sh_p1[BEAT_WIDTH-1:0] : '0;
  assign out_last = active && last_beat;
  assign done     = active && last_beat && out_rdy;

endmodule

// File: rtl/light_tag_checker.sv
// -----------------------------------------------------------------------------
// light_tag_checker
// Pairs each decrypted chunk (plaintext + computed HMAC) with its expected
// tag, compares them, and either releases the plaintext as beats or drops
// the chunk and records an authentication failure.
// Optional build macro: LIGHT_TAG_CHECK_BYPASS_EN -- compare forced to match,
// auth_fail and err_count tied to 0; tag channel still consumed jointly.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   in_plaintext/in_hmac/in_val/in_rdy : chunk channel
//   tag_expected/tag_val/tag_rdy    : expected tag channel
//   out_data/out_last/out_val/out_rdy : plaintext beat stream
//   auth_fail, auth_fail_clr        : sticky mismatch flag and its clear
//   err_count                       : saturating count of dropped chunks
// -----------------------------------------------------------------------------
module light_tag_checker
  import light_pkg::*;
#(
  parameter int PT_WIDTH      = DEF_PT_WIDTH,
  parameter int BEAT_WIDTH    = DEF_BEAT_WIDTH,
  parameter int TAG_WIDTH     = DEF_TAG_WIDTH,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PT_WIDTH-1:0]      in_plaintext,
  input  logic [TAG_WIDTH-1:0]     in_hmac,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [TAG_WIDTH-1:0]     tag_expected,
  input  logic                     tag_val,
  output logic                     tag_rdy,
  output logic [BEAT_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic                     auth_fail,
  input  logic                     auth_fail_clr,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              state, state_nxt;
  logic [PT_WIDTH-1:0] pt_p0;
  logic                fire;
  logic                match;
  logic                load;
  logic                mismatch;
  logic                ser_done;

  // Both channels are consumed together: each side is ready only when the
  // other side is presenting, so the two handshakes always fire as a pair.
  assign fire = (state == IDLE) && in_val && tag_val;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    tag_rdy   = 1'b0;
    load      = 1'b0;
    mismatch  = 1'b0;
    case (state)
      IDLE: begin
        in_rdy  = tag_val;
        tag_rdy = in_val;
        if (fire) state_nxt = CHECK;
      end
      CHECK: begin
        if (match) begin
          load      = 1'b1;
          state_nxt = SEND;
        end else begin
          mismatch  = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (ser_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture on the joint handshake.
  always_ff @(posedge clk) begin
    if (!rst_n)    pt_p0 <= '0;
    else if (fire) pt_p0 <= in_plaintext;
  end

`ifdef LIGHT_TAG_CHECK_BYPASS_EN
  logic unused_bypass;

  assign match         = 1'b1;
  assign auth_fail     = 1'b0;
  assign err_count     = '0;
  assign unused_bypass = ^{in_hmac, tag_expected, auth_fail_clr, mismatch};
`else
  logic [TAG_WIDTH-1:0] hmac_p0;
  logic [TAG_WIDTH-1:0] tag_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hmac_p0 <= '0;
      tag_p0  <= '0;
    end else if (fire) begin
      hmac_p0 <= in_hmac;
      tag_p0  <= tag_expected;
    end
  end

  // Stage p1 (CHECK): full-width compare of the captured pair.
  assign match = (hmac_p0 == tag_p0);

  // A mismatch in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auth_fail <= 1'b0;
      err_count <= '0;
    end else if (mismatch) begin
      auth_fail <= 1'b1;
      err_count <= sat_inc(err_count);
    end else if (auth_fail_clr) begin
      auth_fail <= 1'b0;
    end
  end
`endif

  // Stage p2 (SEND): beat serialization.
  light_beat_serializer #(
    .PT_WIDTH   (PT_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (pt_p0),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_light_tag_checker.sv
// -----------------------------------------------------------------------------
// tb_light_tag_checker
// Self-checking bench for light_tag_checker. A transaction-level reference
// model (pending-check flag, queue of expected beats, sticky flag, error
// count) predicts every output each cycle. A second instance with a 2-bit
// error counter shares the stimulus so that counter saturation is reachable.
// -----------------------------------------------------------------------------
module tb_light_tag_checker;

  localparam int PW = 640;
  localparam int BW = 128;
  localparam int TW = 128;
  localparam int EW = 16;
  localparam int NB = PW / BW;

`ifdef LIGHT_TAG_CHECK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [PW-1:0] in_plaintext;
  logic [TW-1:0] in_hmac, tag_expected;
  logic          in_val, tag_val, out_rdy, auth_fail_clr;
  logic          in_rdy, tag_rdy, out_last, out_val, auth_fail;
  logic [BW-1:0] out_data;
  logic [EW-1:0] err_count;

  logic          s_in_rdy, s_tag_rdy, s_out_last, s_out_val, s_auth_fail;
  logic [BW-1:0] s_out_data;
  logic [1:0]    s_err_count;

  light_tag_checker dut (
    .clk(clk), .rst_n(rst_n),
    .in_plaintext(in_plaintext), .in_hmac(in_hmac), .in_val(in_val), .in_rdy(in_rdy),
    .tag_expected(tag_expected), .tag_val(tag_val), .tag_rdy(tag_rdy),
    .out_data(out_data), .out_last(out_last), .out_val(out_val), .out_rdy(out_rdy),
    .auth_fail(auth_fail), .auth_fail_clr(auth_fail_clr), .err_count(err_count)
  );

  light_tag_checker #(.ERR_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_plaintext(in_plaintext), .in_hmac(in_hmac), .in_val(in_val), .in_rdy(s_in_rdy),
    .tag_expected(tag_expected), .tag_val(tag_val), .tag_rdy(s_tag_rdy),
    .out_data(s_out_data), .out_last(s_out_last), .out_val(s_out_val), .out_rdy(out_rdy),
    .auth_fail(s_auth_fail), .auth_fail_clr(auth_fail_clr), .err_count(s_err_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [BW-1:0] m_q[$];
  bit            m_pend = 1'b0;
  logic [PW-1:0] m_pt;
  logic [TW-1:0] m_h, m_t;
  bit            m_af = 1'b0;
  int unsigned   m_err = 0;

  typedef struct {
    logic [PW-1:0] pt;
    logic [TW-1:0] h;
    logic [TW-1:0] t;
    bit            ok;
  } vec_t;
  vec_t tbl[5];

  function automatic void check1(string nm, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [PW-1:0] rand_pt();
    logic [PW-1:0] v;
    for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [TW-1:0] rand_tag();
    logic [TW-1:0] v;
    for (int i = 0; i < TW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at the falling edge after inputs are driven: checks all outputs
  // against the model, then advances the model across the next rising edge.
  task automatic tick();
    bit idle, ov, acc, ok, mm;
    logic [EW-1:0] ee;
    logic [1:0]    es;
    #1;
    idle = !m_pend && (m_q.size() == 0);
    ov   = !m_pend && (m_q.size() != 0);
    ee   = (m_err > 32'hFFFF) ? 16'hFFFF : 16'(m_err);
    es   = (m_err > 3) ? 2'd3 : 2'(m_err);
    check1("in_rdy", in_rdy, idle && tag_val);
    check1("tag_rdy", tag_rdy, idle && in_val);
    check1("out_val", out_val, ov);
    if (ov) begin
      check1("out_data", out_data, m_q[0]);
      check1("out_last", out_last, m_q.size() == 1);
      check1("sat_out_data", s_out_data, m_q[0]);
    end
    check1("auth_fail", auth_fail, m_af);
    check1("err_count", err_count, ee);
    check1("sat_ctrl", {s_in_rdy, s_tag_rdy, s_out_val, s_auth_fail},
           {idle && tag_val, idle && in_val, ov, m_af});
    check1("sat_err_count", s_err_count, es);
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_pend = 1'b0;
      m_af   = 1'b0;
      m_err  = 0;
    end else begin
      acc = idle && in_val && tag_val;
      mm  = 1'b0;
      if (m_pend) begin
        m_pend = 1'b0;
        ok = BYP || (m_h == m_t);
        if (ok) begin
          for (int k = 0; k < NB; k++) m_q.push_back(m_pt[k*BW +: BW]);
        end else begin
          mm    = 1'b1;
          m_af  = 1'b1;
          m_err = m_err + 1;
        end
      end else if (ov && out_rdy) begin
        void'(m_q.pop_front());
      end
      if (acc) begin
        m_pend = 1'b1;
        m_pt   = in_plaintext;
        m_h    = in_hmac;
        m_t    = tag_expected;
      end
      if (auth_fail_clr && !mm) m_af = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send_chunk(input logic [PW-1:0] pt, input logic [TW-1:0] h, input logic [TW-1:0] t,
                            output int beats, output int first, output bit rdy2);
    in_plaintext = pt; in_hmac = h; tag_expected = t;
    in_val = 1'b1; tag_val = 1'b1; out_rdy = 1'b1;
    tick();
    in_val = 1'b0; tag_val = 1'b1;
    in_plaintext = rand_pt(); in_hmac = rand_tag(); tag_expected = rand_tag();
    beats = 0; first = -1; rdy2 = 1'b0;
    for (int c = 1; c <= NB + 3; c++) begin
      #1;
      if (c == 2) rdy2 = in_rdy;
      if (out_val && first < 0) first = c;
      if (out_val && out_rdy) beats++;
      tick();
    end
    tag_val = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] ramp, pt;
    logic [TW-1:0] a5, h, msk;
    logic [BW-1:0] pdata;
    int            beats, first, e0, cnt;
    bit            rdy2, stalled, plast, okx;

    rst_n = 1'b0; in_val = 1'b0; tag_val = 1'b0; out_rdy = 1'b0; auth_fail_clr = 1'b0;
    in_plaintext = '0; in_hmac = '0; tag_expected = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check1("rst_outputs", {in_rdy, tag_rdy, out_val, out_last, auth_fail}, 5'b0);
    check1("rst_out_data", out_data, 128'h0);
    check1("rst_err_count", err_count, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NB; k++) ramp[k*BW +: BW] = BW'(k);
    a5 = {16{8'hA5}};
    tbl[0] = '{pt: ramp,      h: a5,         t: a5,                   ok: 1'b1};
    tbl[1] = '{pt: ramp,      h: a5,         t: a5 ^ 128'h1,          ok: 1'b0};
    tbl[2] = '{pt: '1,        h: '0,         t: '0,                   ok: 1'b1};
    h = rand_tag();
    tbl[3] = '{pt: rand_pt(), h: h,          t: h ^ {1'b1, 127'h0},   ok: 1'b0};
    h = rand_tag();
    tbl[4] = '{pt: rand_pt(), h: h,          t: h,                    ok: 1'b1};

    // Directed chunks: beat count, latency, ready recovery, error count
    for (int i = 0; i < 5; i++) begin
      okx = BYP || tbl[i].ok;
      e0  = int'(m_err);
      send_chunk(tbl[i].pt, tbl[i].h, tbl[i].t, beats, first, rdy2);
      check1($sformatf("tbl%0d_beats", i), beats, okx ? NB : 0);
      check1($sformatf("tbl%0d_first_val", i), first, okx ? 2 : -1);
      check1($sformatf("tbl%0d_rdy_at2", i), rdy2, !okx);
      check1($sformatf("tbl%0d_err", i), err_count, BYP ? 0 : e0 + (okx ? 0 : 1));
      if (!okx) check1($sformatf("tbl%0d_auth_fail", i), auth_fail, 1'b1);
    end

    // Backpressure: out_rdy pattern 1,0,0,1
    pt = rand_pt(); h = rand_tag();
    in_plaintext = pt; in_hmac = h; tag_expected = h;
    in_val = 1'b1; tag_val = 1'b1; out_rdy = 1'b1;
    tick();
    in_val = 1'b0; tag_val = 1'b1;
    stalled = 1'b0; beats = 0; pdata = '0; plast = 1'b0;
    for (int c = 0; c < 40 && beats < NB; c++) begin
      out_rdy = (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (stalled) begin
        check1("bp_hold_data", out_data, pdata);
        check1("bp_hold_last", out_last, plast);
      end
      if (out_val && out_rdy) begin
        check1("bp_order", out_data, pt[beats*BW +: BW]);
        beats++;
      end
      stalled = out_val && !out_rdy;
      pdata = out_data; plast = out_last;
      tick();
    end
    check1("bp_beats", beats, NB);
    tag_val = 1'b0; out_rdy = 1'b1;
    tick();

    // Handshake pairing: chunk waits for its tag
    pt = rand_pt(); h = rand_tag();
    in_plaintext = pt; in_hmac = h; tag_expected = h;
    in_val = 1'b1; tag_val = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check1("pair_wait_rdy", {in_rdy, tag_rdy}, 2'b01);
      tick();
    end
    tag_val = 1'b1;
    #1;
    check1("pair_accept_rdy", {in_rdy, tag_rdy}, 2'b11);
    tick();
    in_val = 1'b0; tag_val = 1'b0;
    cnt = 0;
    for (int c = 0; c < NB + 3; c++) begin
      #1;
      if (out_val && out_rdy) cnt++;
      tick();
    end
    check1("pair_beats", cnt, NB);

    // Saturation (2-bit instance) plus clear behaviour
    for (int i = 0; i < 4; i++) begin
      h = rand_tag();
      send_chunk(rand_pt(), h, ~h, beats, first, rdy2);
    end
    check1("sat_hold", s_err_count, BYP ? 2'd0 : 2'd3);
    auth_fail_clr = 1'b1;
    tick();
    auth_fail_clr = 1'b0;
    #1;
    check1("clr_alone", auth_fail, 1'b0);
    h = rand_tag();
    in_plaintext = rand_pt(); in_hmac = h; tag_expected = h ^ 128'h2;
    in_val = 1'b1; tag_val = 1'b1;
    tick();
    in_val = 1'b0; tag_val = 1'b0; auth_fail_clr = 1'b1;
    tick();
    auth_fail_clr = 1'b0;
    #1;
    check1("clr_vs_set", auth_fail, !BYP);
    repeat (2) tick();
    auth_fail_clr = 1'b1;
    tick();
    auth_fail_clr = 1'b0;
    #1;
    check1("clr_again", auth_fail, 1'b0);

    // Reset in the middle of SEND
    pt = rand_pt(); h = rand_tag();
    in_plaintext = pt; in_hmac = h; tag_expected = h;
    in_val = 1'b1; tag_val = 1'b1; out_rdy = 1'b1;
    tick();
    in_val = 1'b0; tag_val = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      #1;
      if (out_val && out_rdy) cnt++;
      tick();
    end
    check1("rst_mid_beats_before", cnt, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check1("rst_mid_out", {out_val, out_last, auth_fail}, 3'b0);
    check1("rst_mid_data", out_data, 128'h0);
    check1("rst_mid_err", err_count, 16'h0);
    cnt = 0;
    for (int c = 0; c < NB + 3; c++) begin
      #1;
      if (out_val) cnt++;
      tick();
    end
    check1("rst_mid_no_tail", cnt, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      in_val  = ($urandom_range(3, 0) != 0);
      tag_val = ($urandom_range(3, 0) != 0);
      out_rdy = ($urandom_range(2, 0) != 0);
      auth_fail_clr = ($urandom_range(15, 0) == 0);
      rst_n = ($urandom_range(150, 0) != 0);
      in_plaintext = rand_pt();
      in_hmac = rand_tag();
      msk = '0;
      if ($urandom_range(1, 0) != 0) msk[$urandom_range(TW - 1, 0)] = 1'b1;
      tag_expected = in_hmac ^ msk;
      tick();
    end
    rst_n = 1'b1; in_val = 1'b0; tag_val = 1'b0; out_rdy = 1'b1; auth_fail_clr = 1'b0;
    repeat (NB + 3) tick();
    #1;
    check1("final_idle", out_val, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/light_tag_checker.md
Name: light_tag_checker

Overview:
- Downstream consumer of the light decryptor's response channel: 640-bit plaintext plus 128-bit computed HMAC.
- Pairs each chunk with its expected tag from a separate tag channel and compares them.
- On match, releases the plaintext to the CL as BEAT_WIDTH beats with a last flag.
- On mismatch, drops the chunk, sets a sticky auth_fail flag and bumps a saturating error counter.

Parameters:
PT_WIDTH, 640, plaintext chunk width; must be an integer multiple of BEAT_WIDTH.
BEAT_WIDTH, 128, output beat width.
TAG_WIDTH, 128, HMAC/tag width.
ERR_CNT_WIDTH, 16, error counter width.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, synchronous, active-low.
in_plaintext  in  PT_WIDTH  decrypted chunk.
in_hmac  in  TAG_WIDTH  computed HMAC for the chunk.
in_val  in  1  chunk valid.
in_rdy  out  1  chunk accepted when in_val && in_rdy.
tag_expected  in  TAG_WIDTH  expected tag from the host/metadata path.
tag_val  in  1  tag valid.
tag_rdy  out  1  tag accepted when tag_val && tag_rdy.
out_data  out  BEAT_WIDTH  plaintext beat.
out_last  out  1  final beat of a chunk.
out_val  out  1  beat valid.
out_rdy  in  1  beat accepted.
auth_fail  out  1  sticky, set on any tag mismatch.
auth_fail_clr  in  1  clears auth_fail.
err_count  out  ERR_CNT_WIDTH  number of dropped chunks; saturates.

Behaviour:
- NUM_BEATS = PT_WIDTH/BEAT_WIDTH (5 at defaults). Beat index counter is clog2(NUM_BEATS) bits wide.
- Reset values: in_rdy=0, tag_rdy=0, out_val=0, out_last=0, out_data=0, auth_fail=0, err_count=0. State=IDLE and all capture registers are zeroed.
- FSM IDLE:
  - Joint consumption: in_rdy = tag_val, tag_rdy = in_val.
  - Both handshakes fire in the same cycle, or neither fires.
  - On fire: register plaintext, computed HMAC and expected tag; go to CHECK.
- FSM CHECK (exactly 1 cycle):
  - Full-width equality compare of the registered HMAC and registered tag.
  - Match: go to SEND with beat_idx=0.
  - Mismatch: go to IDLE; set auth_fail; err_count += 1, saturating at all-ones (no wrap).
  - No output beat is ever emitted for a failed chunk.
- FSM SEND:
  - out_val=1; out_data = pt_r[beat_idx*BEAT_WIDTH +: BEAT_WIDTH], least-significant beat first.
  - out_last=1 iff beat_idx==NUM_BEATS-1.
  - On out_rdy: beat_idx++. After the last beat is accepted, go to IDLE.
  - While out_val && !out_rdy, out_data and out_last are held stable.
- in_rdy and tag_rdy are 0 in CHECK and SEND.
- Latency: first beat out_val is asserted 2 cycles after input acceptance.
- Best-case throughput: one chunk per NUM_BEATS+2 cycles.
- auth_fail_clr: clears auth_fail next cycle. If asserted in the same cycle as a new mismatch, set wins. Does not affect err_count.
- Reset mid-operation (any state): the buffered chunk is discarded with no partial tail; all outputs return to reset values the next cycle.
- Inputs in_plaintext/in_hmac need only be valid in the handshake cycle.

Optional Feature:
- Macro LIGHT_TAG_CHECK_BYPASS_EN.
- Defined:
  - The compare is forced to match; every accepted chunk is released.
  - The tag channel is still consumed jointly, so handshake timing is unchanged.
  - auth_fail and err_count are tied to 0.
- Undefined: full checking as above.

Decomposition:
- Package light_pkg:
  - State enum {IDLE, CHECK, SEND}.
  - Default width constants: PT_WIDTH, BEAT_WIDTH, TAG_WIDTH.
  - NUM_BEATS computation function.
- Natural sub-module light_beat_serializer:
  - PISO from PT_WIDTH to BEAT_WIDTH with val/rdy/last.
  - Loaded in CHECK on match; signals done to the FSM.
- Existing shield counter and register primitives are reused for beat_idx, err_count and the capture registers.

Test Plan:
- Matching chunk: in_plaintext = 0x0004_..._0000 (beat k holds value k), hmac = tag = 0xA5A5...A5. Required: 5 beats with values 0,1,2,3,4; out_last on beat 4; first out_val 2 cycles after accept; auth_fail=0.
- Mismatch: tag differs from hmac in bit 0. Required: no out_val; auth_fail=1; err_count=1; in_rdy high again 2 cycles after accept.
- Backpressure: out_rdy toggles 1,0,0,1 per cycle during SEND. Required: out_data/out_last stable while stalled; 5 beats delivered in order; in_rdy stays 0 until the last beat is accepted.
- Handshake pairing: in_val high for 3 cycles with tag_val low, then tag_val rises. Required: in_rdy=0 and tag_rdy=1 during the wait; single joint accept in the cycle tag_val rises.
- Saturation and clear: force err_count to 0xFFFF then a mismatch → count stays 0xFFFF. auth_fail_clr asserted in the same cycle CHECK sees a mismatch → auth_fail=1. Clear alone → auth_fail=0.
- Reset mid-SEND: assert rst_n=0 after beat 2 is accepted. Required: out_val=0 next cycle, no further beats, err_count=0. With LIGHT_TAG_CHECK_BYPASS_EN defined, the mismatch stimulus releases 5 beats and auth_fail stays 0.
